// File: rtl/jesd204_rx_cgs_pkg.sv
// Shared types and constants for the JESD204B RX code group synchronization stage.
package jesd204_rx_cgs_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CHECK = 2'd1,
        DATA  = 2'd2
    } cgs_state_t;

    localparam logic [7:0] K28_5     = 8'hBC;
    localparam int         CGS_MIN_K = 4;
    localparam int         ERR_LIMIT = 3;

    function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[4] ? 4'hF : sum[3:0];
    endfunction

endpackage

// File: rtl/jesd204_rx_cgs_if.sv
// Decoded-character bus into the CGS stage and qualified character bus out of it.
interface jesd204_rx_cgs_if #(
    parameter int DATA_PATH_WIDTH = 4
);
    logic [DATA_PATH_WIDTH*8-1:0] in_char;
    logic [DATA_PATH_WIDTH-1:0]   in_charisk;
    logic [DATA_PATH_WIDTH-1:0]   in_notintable;
    logic [DATA_PATH_WIDTH-1:0]   in_disperr;
    logic [DATA_PATH_WIDTH*8-1:0] out_char;
    logic [DATA_PATH_WIDTH-1:0]   out_charisk;
    logic                         out_valid;

    modport master (
        output in_char, in_charisk, in_notintable, in_disperr,
        input  out_char, out_charisk, out_valid
    );

    modport slave (
        input  in_char, in_charisk, in_notintable, in_disperr,
        output out_char, out_charisk, out_valid
    );
endinterface

// File: rtl/jesd204_rx_cgs_beat_classify.sv
// Combinational per-beat classification: clean, all-K28.5, trailing K28.5 run, invalid count.
module jesd204_rx_cgs_beat_classify
    import jesd204_rx_cgs_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic [DATA_PATH_WIDTH*8-1:0] beat_char,
    input  logic [DATA_PATH_WIDTH-1:0]   beat_charisk,
    input  logic [DATA_PATH_WIDTH-1:0]   beat_notintable,
    input  logic [DATA_PATH_WIDTH-1:0]   beat_disperr,
    output logic                         clean,
    output logic                         all_k,
    output logic [3:0]                   trail_k,
    output logic [3:0]                   err_pop
);

    logic [DATA_PATH_WIDTH-1:0] invalid;
    logic [DATA_PATH_WIDTH-1:0] is_k;
    logic                       run_on;

    always_comb begin
        invalid = beat_notintable | beat_disperr;
        is_k    = '0;
        for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
            is_k[i] = !invalid[i] && beat_charisk[i] && (beat_char[8*i +: 8] == K28_5);
        end
    end

    assign clean = ~|invalid;
    assign all_k = &is_k;

    // Run is counted from the last character of the beat back toward char 0.
    always_comb begin
        trail_k = '0;
        run_on  = 1'b1;
        for (int i = DATA_PATH_WIDTH - 1; i >= 0; i--) begin
            if (run_on && is_k[i]) begin
                trail_k = trail_k + 4'd1;
            end else begin
                run_on = 1'b0;
            end
        end
    end

    always_comb begin
        err_pop = '0;
        for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
            err_pop = err_pop + 4'(invalid[i]);
        end
    end

endmodule

// File: rtl/jesd204_rx_cgs.sv
// Per-lane JESD204B CGS state machine, ready flag and character forwarding.
// Optional lifetime invalid-character counter: define JESD204_RX_CGS_ERR_TOTAL_EN.
//
// state | meaning
// INIT  | hunting for CGS_MIN_K consecutive K28.5 characters
// CHECK | CGS achieved, still receiving K28.5; ready asserted
// DATA  | ILAS/user data flowing; out_valid asserted
module jesd204_rx_cgs
    import jesd204_rx_cgs_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    jesd204_rx_cgs_if.slave       lane,
    output logic                  ready,
    output logic [1:0]            state,
    output logic [31:0]           err_total
);

    cgs_state_t state_q, state_d;
    logic [3:0] k_q, k_d, k_upd;
    logic [1:0] err_q, err_d, err_upd;
    logic       clean, all_k;
    logic [3:0] trail_k, err_pop;

    jesd204_rx_cgs_beat_classify #(
        .DATA_PATH_WIDTH (DATA_PATH_WIDTH)
    ) u_classify (
        .beat_char       (lane.in_char),
        .beat_charisk    (lane.in_charisk),
        .beat_notintable (lane.in_notintable),
        .beat_disperr    (lane.in_disperr),
        .clean           (clean),
        .all_k           (all_k),
        .trail_k         (trail_k),
        .err_pop         (err_pop)
    );

    assign k_upd = all_k ? sat_add4(k_q, 4'(DATA_PATH_WIDTH)) : trail_k;

    always_comb begin
        err_upd = err_q;
        if (clean) begin
            if (err_q != 2'd0) err_upd = err_q - 2'd1;
        end else if (err_q != 2'd3) begin
            err_upd = err_q + 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_upd;
        err_d   = err_upd;
        if (!enable) begin
            state_d = INIT;
            k_d     = '0;
            err_d   = '0;
        end else begin
            case (state_q)
                INIT: begin
                    err_d = '0;
                    if (k_upd >= 4'(CGS_MIN_K)) state_d = CHECK;
                end
                CHECK, DATA: begin
                    if (err_upd == 2'(ERR_LIMIT)) begin
                        state_d = INIT;
                        k_d     = '0;
                        err_d   = '0;
                    end else if (state_q == CHECK && clean && !all_k) begin
                        state_d = DATA;
                    end
                end
                default: begin
                    state_d = INIT;
                    k_d     = '0;
                    err_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= INIT;
            k_q              <= '0;
            err_q            <= '0;
            ready            <= 1'b0;
            lane.out_valid   <= 1'b0;
            lane.out_char    <= '0;
            lane.out_charisk <= '0;
        end else begin
            state_q          <= state_d;
            k_q              <= k_d;
            err_q            <= err_d;
            ready            <= (state_d != INIT);
            lane.out_valid   <= (state_d == DATA);
            lane.out_char    <= lane.in_char;
            lane.out_charisk <= lane.in_charisk;
        end
    end

    assign state = state_q;

`ifdef JESD204_RX_CGS_ERR_TOTAL_EN
    logic [31:0] err_total_q;
    logic [32:0] err_total_sum;

    assign err_total_sum = {1'b0, err_total_q} + 33'(err_pop);

    // Counts in every state and survives enable drops; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_total_q <= '0;
        end else begin
            err_total_q <= err_total_sum[32] ? 32'hFFFF_FFFF : err_total_sum[31:0];
        end
    end

    assign err_total = err_total_q;
`else
    logic unused_err_pop;
    assign unused_err_pop = ^err_pop;
    assign err_total      = '0;
`endif

endmodule

// File: tb/tb_jesd204_rx_cgs.sv
// Self-checking bench for jesd204_rx_cgs: directed table, corner sequences, randomized model compare.
module tb_jesd204_rx_cgs;
    import jesd204_rx_cgs_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        en4, en1;
    logic        ready4, ready1;
    logic [1:0]  st4, st1;
    logic [31:0] tot4, tot1;

    int total = 0;
    int bad   = 0;

    jesd204_rx_cgs_if #(.DATA_PATH_WIDTH(4)) lane4 ();
    jesd204_rx_cgs_if #(.DATA_PATH_WIDTH(1)) lane1 ();

    jesd204_rx_cgs #(.DATA_PATH_WIDTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .enable    (en4),
        .lane      (lane4.slave),
        .ready     (ready4),
        .state     (st4),
        .err_total (tot4)
    );

    jesd204_rx_cgs #(.DATA_PATH_WIDTH(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .enable    (en1),
        .lane      (lane1.slave),
        .ready     (ready1),
        .state     (st1),
        .err_total (tot1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     run;
        int     err;
        int     st;
        longint tot;
    } mdl_t;

    typedef struct {
        logic [31:0] ch;
        logic [3:0]  k;
        logic [3:0]  de;
        logic        en;
        int          st;
        logic        rdy;
        logic        vld;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic [31:0] ch, input logic [3:0] k, input logic [3:0] nit,
                          input logic [3:0] de, input logic en);
        lane4.in_char       = ch;
        lane4.in_charisk    = k;
        lane4.in_notintable = nit;
        lane4.in_disperr    = de;
        en4                 = en;
    endtask

    task automatic drive1(input logic [7:0] ch, input logic k, input logic nit,
                          input logic de, input logic en);
        lane1.in_char       = ch;
        lane1.in_charisk    = k;
        lane1.in_notintable = nit;
        lane1.in_disperr    = de;
        en1                 = en;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive4(32'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        drive1(8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Character-stream view: a K28.5 run counter walked char by char, error budget, state.
    function automatic mdl_t mstep(input mdl_t m, input int w, input logic [31:0] ch,
                                   input logic [3:0] k, input logic [3:0] nit,
                                   input logic [3:0] de, input logic en);
        int nbad = 0;
        int nk   = 0;
        int run  = m.run;
        for (int i = 0; i < w; i++) begin
            logic inv;
            inv = nit[i] | de[i];
            if (inv) nbad++;
            if (!inv && k[i] && ch[8*i +: 8] == 8'hBC) begin
                nk++;
                run = (run < 15) ? run + 1 : 15;
            end else begin
                run = 0;
            end
        end
`ifdef JESD204_RX_CGS_ERR_TOTAL_EN
        m.tot = m.tot + nbad;
        if (m.tot > 64'hFFFF_FFFF) m.tot = 64'hFFFF_FFFF;
`endif
        if (!en) begin
            m.st = 0; m.run = 0; m.err = 0;
        end else if (m.st == 0) begin
            m.run = run;
            m.err = 0;
            if (run >= 4) m.st = 1;
        end else begin
            int e;
            e = (nbad == 0) ? ((m.err > 0) ? m.err - 1 : 0) : m.err + 1;
            if (e >= 3) begin
                m.st = 0; m.run = 0; m.err = 0;
            end else begin
                m.err = e;
                m.run = run;
                if (m.st == 1 && nbad == 0 && nk != w) m.st = 2;
            end
        end
        return m;
    endfunction

    task automatic rand_char(output logic [7:0] c, output logic k, output logic nit, output logic de);
        int r;
        r = $urandom_range(0, 99);
        if (r < 75) begin
            c = 8'hBC; k = 1'b1;
        end else if (r < 82) begin
            c = 8'h1C; k = 1'b1;
        end else begin
            c = 8'($urandom); k = 1'b0;
        end
        nit = ($urandom_range(0, 99) < 3);
        de  = ($urandom_range(0, 99) < 3);
    endtask

    initial begin
        mdl_t        m4, m1;
        logic [31:0] ch4;
        logic [3:0]  k4, n4, d4;
        logic [7:0]  c1;
        logic        k1, n1, d1, e4, e1, rst;
        logic [31:0] exp_ch4;
        logic [3:0]  exp_k4;
        logic [7:0]  exp_ch1;
        logic        exp_k1;

        tbl[0]  = '{32'hBCBCBCBC, 4'hF, 4'h0, 1'b1, 1, 1'b1, 1'b0};
        tbl[1]  = '{32'h1C1C1C1C, 4'h0, 4'h0, 1'b1, 2, 1'b1, 1'b1};
        tbl[2]  = '{32'h11223344, 4'h0, 4'h0, 1'b1, 2, 1'b1, 1'b1};
        tbl[3]  = '{32'h11223344, 4'h0, 4'h1, 1'b1, 2, 1'b1, 1'b1};
        tbl[4]  = '{32'h11223344, 4'h0, 4'h1, 1'b1, 2, 1'b1, 1'b1};
        tbl[5]  = '{32'h11223344, 4'h0, 4'h1, 1'b1, 0, 1'b0, 1'b0};
        tbl[6]  = '{32'hBCBCBCBC, 4'hF, 4'h0, 1'b1, 1, 1'b1, 1'b0};
        tbl[7]  = '{32'h55667788, 4'h0, 4'h0, 1'b1, 2, 1'b1, 1'b1};
        tbl[8]  = '{32'h55667788, 4'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0};
        tbl[9]  = '{32'hBCBCBCBC, 4'hF, 4'h0, 1'b1, 1, 1'b1, 1'b0};
        tbl[10] = '{32'hBCBCBCBC, 4'hF, 4'h0, 1'b1, 1, 1'b1, 1'b0};
        tbl[11] = '{32'hBCBCBC1C, 4'hF, 4'h0, 1'b1, 2, 1'b1, 1'b1};
        tbl[12] = '{32'h1C1C1C1C, 4'hF, 4'h0, 1'b1, 2, 1'b1, 1'b1};

        do_reset();
        chk("reset_state", 64'(st4), 64'd0);
        chk("reset_ready", 64'(ready4), 64'd0);
        chk("reset_valid", 64'(lane4.out_valid), 64'd0);
        chk("reset_char", 64'(lane4.out_char), 64'd0);
        chk("reset_total", 64'(tot4), 64'd0);

        for (int i = 0; i < 13; i++) begin
            drive4(tbl[i].ch, tbl[i].k, 4'h0, tbl[i].de, tbl[i].en);
            tick();
            chk($sformatf("tbl%0d_state", i), 64'(st4), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_ready", i), 64'(ready4), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_valid", i), 64'(lane4.out_valid), 64'(tbl[i].vld));
            chk($sformatf("tbl%0d_char", i), 64'(lane4.out_char), 64'(tbl[i].ch));
            chk($sformatf("tbl%0d_charisk", i), 64'(lane4.out_charisk), 64'(tbl[i].k));
        end

        // Alternating bad/clean beats in DATA must never reach the error limit.
        for (int i = 0; i < 10; i++) begin
            drive4(32'h0A0B0C0D, 4'h0, 4'h0, (i % 2 == 0) ? 4'h1 : 4'h0, 1'b1);
            tick();
            chk($sformatf("decay%0d_ready", i), 64'(ready4), 64'd1);
            chk($sformatf("decay%0d_state", i), 64'(st4), 64'd2);
            chk($sformatf("decay%0d_errle1", i), 64'(dut4.err_q <= 2'd1), 64'd1);
        end

        // Single-character lanes: a K28.5 run broken at 3 must restart from zero.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) drive1(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
            else        drive1(8'hBC, 1'b1, 1'b0, 1'b0, 1'b1);
            tick();
            chk($sformatf("dpw1_beat%0d_ready", i), 64'(ready1), (i == 7) ? 64'd1 : 64'd0);
        end

`ifdef JESD204_RX_CGS_ERR_TOTAL_EN
        do_reset();
        drive4(32'h0, 4'h0, 4'b1011, 4'h0, 1'b1);
        tick();
        chk("macro_total3", 64'(tot4), 64'd3);
        chk("macro_state", 64'(st4), 64'd0);
        drive4(32'h0, 4'h0, 4'h0, 4'b0110, 1'b0);
        tick();
        chk("macro_total_en0", 64'(tot4), 64'd5);
`endif

        do_reset();
        m4 = '{0, 0, 0, 0};
        m1 = '{0, 0, 0, 0};
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < 4; i++) begin
                logic [7:0] c;
                logic kk, nn, dd;
                rand_char(c, kk, nn, dd);
                ch4[8*i +: 8] = c;
                k4[i] = kk;
                n4[i] = nn;
                d4[i] = dd;
            end
            rand_char(c1, k1, n1, d1);
            e4  = ($urandom_range(0, 99) >= 3);
            e1  = ($urandom_range(0, 99) >= 3);
            rst = ($urandom_range(0, 199) == 0);
            drive4(ch4, k4, n4, d4, e4);
            drive1(c1, k1, n1, d1, e1);
            reset = rst;
            if (rst) begin
                m4 = '{0, 0, 0, 0};
                m1 = '{0, 0, 0, 0};
                exp_ch4 = '0; exp_k4 = '0; exp_ch1 = '0; exp_k1 = 1'b0;
            end else begin
                m4 = mstep(m4, 4, ch4, k4, n4, d4, e4);
                m1 = mstep(m1, 1, {24'h0, c1}, {3'b0, k1}, {3'b0, n1}, {3'b0, d1}, e1);
                exp_ch4 = ch4; exp_k4 = k4; exp_ch1 = c1; exp_k1 = k1;
            end
            tick();
            reset = 1'b0;
            chk("rnd4_state", 64'(st4), 64'(m4.st));
            chk("rnd4_ready", 64'(ready4), 64'(m4.st != 0));
            chk("rnd4_valid", 64'(lane4.out_valid), 64'(m4.st == 2));
            chk("rnd4_char", 64'(lane4.out_char), 64'(exp_ch4));
            chk("rnd4_charisk", 64'(lane4.out_charisk), 64'(exp_k4));
            chk("rnd4_total", 64'(tot4), 64'(m4.tot));
            chk("rnd1_state", 64'(st1), 64'(m1.st));
            chk("rnd1_ready", 64'(ready1), 64'(m1.st != 0));
            chk("rnd1_valid", 64'(lane1.out_valid), 64'(m1.st == 2));
            chk("rnd1_char", 64'(lane1.out_char), 64'(exp_ch1));
            chk("rnd1_charisk", 64'(lane1.out_charisk), 64'(exp_k1));
            chk("rnd1_total", 64'(tot1), 64'(m1.tot));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
